// File: rtl/fetch_decode_queue.sv
// In-order instruction queue between fetch and decode. Write-to-head latency is one cycle, with no bypass.
// Fetch is stalled through pc_we when the queue is full, halted or being flushed. Decode drains the queue with valid/ready.
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 40,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_valid,
    input  logic [IW-1:0]            f_instr,
    input  logic [AW-1:0]            f_pc,
    input  logic [AW-1:0]            f_next_pc,
    output logic                     pc_we,
    input  logic                     flush,
    output logic                     d_valid,
    input  logic                     d_ready,
    output logic [IW-1:0]            d_instr,
    output logic [AW-1:0]            d_pc,
    output logic [AW-1:0]            d_next_pc,
    output logic [2:0]               d_len,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
        logic [AW-1:0] next_pc;
        logic [2:0]    len;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    entry_t        wr_entry;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          halt_q;
    logic          full;
    logic          enq;
    logic          deq;
    logic [AW-1:0] diff;

    assign full    = (cnt == CW'(DEPTH));
    assign pc_we   = !full && !halt_q && !flush;
    assign d_valid = (cnt != '0);
    assign enq     = f_valid && pc_we;
    assign deq     = d_valid && d_ready;
    assign halted  = halt_q;
    assign count   = cnt;

    // Length only makes sense for a sequential fetch; jumps and stalled fetches encode 0.
    always_comb begin
        diff             = f_next_pc - f_pc;
        wr_entry.instr   = f_instr;
        wr_entry.pc      = f_pc;
        wr_entry.next_pc = f_next_pc;
        wr_entry.len     = 3'd0;
        if (diff >= AW'(1) && diff <= AW'(5)) begin
            wr_entry.len = diff[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            halt_q <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq && !deq) begin
                cnt <= cnt + CW'(1);
            end else if (deq && !enq) begin
                cnt <= cnt - CW'(1);
            end
            if (enq && f_instr[7:0] == 8'hF4) begin
                halt_q <= 1'b1;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign d_instr   = d_valid ? head.instr   : '0;
    assign d_pc      = d_valid ? head.pc      : '0;
    assign d_next_pc = d_valid ? head.next_pc : '0;
    assign d_len     = d_valid ? head.len     : 3'd0;

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Consumer-side instruction buffer between fetch_stage and the decode stage.
- Accepts one fetched {instr, pc, next_pc} bundle per cycle and presents them to decode in order, first-word fall-through.
- Drives pc_we back to fetch_stage to stall the PC when full or halted.
- Drops all buffered work on a redirect flush and latches HLT (opcode 0xF4) to stop further fetch.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- IW, 40, instruction bundle width; opcode is bits [7:0].
- AW, 32, PC width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- f_valid  input  1  fetch_stage presents a valid bundle this cycle.
- f_instr  input  IW  fetched instruction bytes; byte 0 in [7:0].
- f_pc  input  AW  PC of f_instr.
- f_next_pc  input  AW  next_pc computed by fetch_stage.
- pc_we  output  1  to fetch_stage; 1 = bundle accepted and PC may advance.
- flush  input  1  taken jump/redirect from downstream; discard all entries.
- d_valid  output  1  head entry valid.
- d_ready  input  1  decode consumes the head this cycle.
- d_instr  output  IW  head instruction.
- d_pc  output  AW  head PC.
- d_next_pc  output  AW  head next PC.
- d_len  output  3  head instruction length, 1..5; 0 = non-sequential.
- halted  output  1  HLT has been enqueued; fetch is frozen.
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry circular buffer; rd_ptr and wr_ptr are clog2(DEPTH) bits, wrap modulo DEPTH; count is 0..DEPTH.
- Reset (rst=1 at edge): count=0, pointers=0, halted=0.
  - Outputs settle to pc_we=1 (combinational), d_valid=0, d_instr/d_pc/d_next_pc/d_len=0.
- pc_we = !full & !halted & !flush. This is combinational, with no dependence on f_valid or d_ready.
- Enqueue when f_valid & pc_we. The entry is written at wr_ptr and becomes visible on d_* the next cycle. There is no same-cycle bypass, even when empty.
- Dequeue when d_valid & d_ready. The head advances at the edge.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- When full, pc_we=0, so no enqueue occurs even if decode dequeues in the same cycle. Fetch retries next cycle.
- d_* show the head entry combinationally when d_valid=1 (d_valid = count!=0). When d_valid=0 they are forced to 0.
- d_len is computed at enqueue as diff = f_next_pc - f_pc (AW-bit modulo subtraction).
  - If diff is in 1..5, store diff[2:0].
  - Otherwise (jump target, or stalled fetch where next_pc=pc), store 0.
- HLT detection: an enqueue with f_instr[7:0]==8'hF4 stores the HLT entry normally and sets halted=1 at that edge.
  - While halted=1, pc_we=0 and nothing is enqueued.
  - Existing entries, including the HLT, still drain to decode.
- flush=1 at an edge: count=0, rd_ptr=wr_ptr=0, halted=0. The input bundle that cycle is discarded (pc_we is already 0). Any dequeue that cycle is ignored.
- Priority at each edge: rst > flush > normal enqueue/dequeue.
- rst or flush mid-stream drops all entries; d_valid=0 in the following cycle.
- f_valid=0: no enqueue. pc_we is still driven per its equation.
- d_ready while d_valid=0 has no effect.
- No overflow or underflow is possible; the design contains no assertion outputs.

Test Plan:
- Reset, then fill in order:
  - Stimulus: enqueue {pc=0,next=1,op=90}, {pc=1,next=3,op=01}, {pc=3,next=6,op=83}, {pc=6,next=11,op=B8} with d_ready=0.
  - Response: count=4, pc_we=0 after the 4th.
  - Then d_ready=1: d_pc sequence 0,1,3,6; d_len sequence 1,2,3,5; d_valid falls after 4 cycles.
- Empty-queue latency: enqueue {pc=0,next=1} at cycle N.
  - Response: d_valid=0 during N, d_valid=1 with d_pc=0 at N+1.
- Full with concurrent dequeue: count=4, f_valid=1, d_ready=1.
  - Response: pc_we=0, the new bundle is not stored, count goes 3.
  - Next cycle pc_we=1 and the bundle is accepted.
- Jump bundle: enqueue {pc=0, next_pc=DEADBEEF}.
  - Response: d_len=0, d_next_pc=DEADBEEF.
  - Then flush=1 with 2 entries queued: count=0, d_valid=0 next cycle, and the simultaneous f_valid bundle is dropped.
- HLT: enqueue op=F4 at pc=8 (next=9), then keep f_valid=1.
  - Response: halted=1, pc_we=0; the HLT is delivered with d_len=1; no further entries are accepted.
  - flush clears halted and pc_we returns to 1.
- Reset mid-operation: count=3, assert rst for 1 cycle.
  - Response: count=0, d_valid=0, d_* =0, halted=0, pc_we=1.
